fpnew_noncomp_collector: RTL and testbench
==========================================

# fpnew_noncomp_collector

Responder for the result side of the `fpnew_noncomp` unit. It accepts the unit's `out_valid_o`/`out_ready_i` handshake and buffers each result with its status, class and tag fields in a DEPTH-entry FIFO. It presents results in order to the integer/FP writeback port through a second valid/ready handshake. It also keeps sticky accumulated fflags and a count of completed operations.

## Interface
Parameters:
- `WIDTH`, 32: FP operand/result width; must be ≥ 10.
- `TAG_WIDTH`, 1: width of the tag carried alongside each result.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_WIDTH`, 16: width of the completed-operation counter.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `flush_i`, input, 1: synchronous FIFO flush.
- `in_valid_i`, input, 1: result valid; driven from the unit's `out_valid_o`.
- `in_ready_o`, output, 1: collector can accept; drives the unit's `out_ready_i`.
- `result_i`, input, WIDTH: unit result.
- `status_i`, input, 5: `{NV,DZ,OF,UF,NX}`.
- `extension_bit_i`, input, 1: NaN-boxing extension bit.
- `class_mask_i`, input, 10: classify one-hot mask.
- `is_class_i`, input, 1: result is a classify.
- `tag_i`, input, TAG_WIDTH: operation tag.
- `wb_valid_o`, output, 1: head entry valid.
- `wb_ready_i`, input, 1: writeback accepts.
- `wb_data_o`, output, WIDTH: if the head `is_class` is set, `{(WIDTH-10)'b0, class_mask}`; otherwise `result`.
- `wb_ext_o`, output, 1: head extension bit.
- `wb_status_o`, output, 5: head status.
- `wb_tag_o`, output, TAG_WIDTH: head tag.
- `fflags_o`, output, 5: sticky OR of the status of every dequeued result.
- `fflags_clr_i`, input, 1: clear sticky fflags.
- `done_cnt_o`, output, CNT_WIDTH: number of dequeued results; wraps modulo 2^CNT_WIDTH.
- `occupancy_o`, output, $clog2(DEPTH)+1: number of entries held.

## Operation
- Push: `push = in_valid_i & in_ready_o & ~flush_i`. The entry written is `{result, status, ext, class_mask, is_class, tag}`.
- Pop: `pop = wb_valid_o & wb_ready_i`. A pop is honoured even when `flush_i` is high, because the data has already been handed off.
- `in_ready_o = (occupancy < DEPTH)`. It is derived from registered occupancy only.
  - When the FIFO is full, `in_ready_o` is 0 even if a pop occurs in the same cycle. There is no full-pass-through.
- `wb_valid_o = (occupancy != 0)`. There is no empty bypass, so a result is never visible in its push cycle.
- Pointers: read and write pointers are each `$clog2(DEPTH)` bits and wrap naturally.
- Occupancy update rules:
  - Push and pop in the same cycle: occupancy is unchanged and both pointers advance.
  - `flush_i`: next occupancy is 0 and both pointers reset to 0. This overrides push and pop in the same cycle. Storage contents are don't-care.
- fflags update: `fflags_next = (fflags_clr_i ? 0 : fflags) | (pop ? head.status : 0)`. A clear and a pop in the same cycle leave only the popped status.
- Counter: `done_cnt` increments by 1 on each pop, from all-ones to 0 on wrap.
- Neither `flush_i` nor `fflags_clr_i` affects `done_cnt`. `flush_i` does not clear fflags.
- Head outputs (`wb_data_o`, `wb_ext_o`, `wb_status_o`, `wb_tag_o`) are read combinationally from the entry at the read pointer. They are held stable while `wb_valid_o & ~wb_ready_i`.
- All outputs are X-free after reset.
  - Head outputs show entry 0. Storage is cleared on reset, so they read 0.

## Timing
- Reset (asynchronous assertion, synchronous release at the next edge):
  - `in_ready_o` = 1.
  - `wb_valid_o` = 0.
  - `wb_data_o`, `wb_ext_o`, `wb_status_o`, `wb_tag_o` = 0.
  - `fflags_o` = 0.
  - `done_cnt_o` = 0.
  - `occupancy_o` = 0.
- Reset during a transfer discards every entry. The unit sees `in_ready_o` = 1 while reset is held.
- Latency:
  - A push at edge N gives `wb_valid_o` = 1 in cycle N+1.
  - A pop at edge N updates `fflags_o` and `done_cnt_o` in cycle N+1.
- Throughput is one push and one pop per cycle in steady state, provided occupancy is between 1 and DEPTH-1.
- From a full FIFO, a pop at edge N raises `in_ready_o` in cycle N+1.
- Handshake rule: the unit must hold `in_valid_i` and its data while `in_ready_o` = 0. The collector never drops an offered result except when `flush_i` is high.

## Test plan
- Single MINMAX result:
  - Stimulus: after reset, push `result_i`=0x3F800000, `status_i`=0, `tag_i`=1, `is_class_i`=0, with `wb_ready_i`=1.
  - Required: `wb_valid_o`=1 one cycle later with `wb_data_o`=0x3F800000 and `wb_tag_o`=1. Next cycle `done_cnt_o`=1, `occupancy_o`=0, `fflags_o`=0.
- Classify:
  - Stimulus: push `is_class_i`=1, `class_mask_i`=10'h040, `result_i`=0xDEADBEEF.
  - Required: `wb_data_o`=0x00000040.
- Backpressure and full:
  - Stimulus: hold `wb_ready_i`=0 and push 5 results 0x1..0x5 back-to-back.
  - Required: `in_ready_o`=0 after the 4th push, with `occupancy_o`=4. Result 0x5 is held by the unit.
  - Then raise `wb_ready_i`. Required: outputs appear in order 0x1..0x5, `in_ready_o` returns 1 one cycle after the first pop, and 0x5 is pushed then.
- Sticky flags:
  - Stimulus: dequeue statuses 5'b10000 then 5'b00001.
  - Required: `fflags_o`=5'b10001.
  - Stimulus: assert `fflags_clr_i` in the same cycle as popping status 5'b00100.
  - Required: `fflags_o`=5'b00100.
- Flush:
  - Stimulus: with 3 entries held, assert `flush_i` while `in_valid_i`=1 and `wb_ready_i`=1.
  - Required: the head is counted (`done_cnt_o` +1), the pushed result is dropped, `occupancy_o`=0 and `wb_valid_o`=0 the next cycle, and `fflags_o` includes the popped status.
- Async reset:
  - Stimulus: assert `rst_i` mid-cycle with 2 entries held.
  - Required: `wb_valid_o`=0, `occupancy_o`=0 and `in_ready_o`=1 before the next clock edge.
  - Counter wrap: with `CNT_WIDTH`=4, 17 pops give `done_cnt_o`=1.

Source files
------------

// File: rtl/fpnew_noncomp_collector_if.sv
// fpnew_noncomp_collector_if
//   Groups both handshakes around the collector:
//   - the result side of fpnew_noncomp (in_*), where the unit offers a
//     result and the collector answers with in_ready_o
//   - the writeback side (wb_*), where the collector presents its head
//     entry to the integer/FP writeback port
//   Signal suffixes are from the collector's point of view.
//   modport master : the environment (unit + writeback port)
//   modport slave  : the collector itself
interface fpnew_noncomp_collector_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 1
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     result_i;
  logic [4:0]           status_i;
  logic                 extension_bit_i;
  logic [9:0]           class_mask_i;
  logic                 is_class_i;
  logic [TAG_WIDTH-1:0] tag_i;

  logic                 wb_valid_o;
  logic                 wb_ready_i;
  logic [WIDTH-1:0]     wb_data_o;
  logic                 wb_ext_o;
  logic [4:0]           wb_status_o;
  logic [TAG_WIDTH-1:0] wb_tag_o;

  modport master (
    output in_valid_i, result_i, status_i, extension_bit_i,
           class_mask_i, is_class_i, tag_i, wb_ready_i,
    input  in_ready_o, wb_valid_o, wb_data_o, wb_ext_o, wb_status_o, wb_tag_o
  );

  modport slave (
    input  in_valid_i, result_i, status_i, extension_bit_i,
           class_mask_i, is_class_i, tag_i, wb_ready_i,
    output in_ready_o, wb_valid_o, wb_data_o, wb_ext_o, wb_status_o, wb_tag_o
  );
endinterface

// File: rtl/fpnew_noncomp_collector.sv
// fpnew_noncomp_collector
//   Buffers results of the fpnew_noncomp unit in a DEPTH-entry FIFO and hands
//   them in order to the writeback port. Also keeps sticky fflags (OR of the
//   status of every dequeued result) and a wrapping count of dequeued results.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   flush_i      : synchronous flush of the FIFO (an accepted pop still counts)
//   bus          : result-side and writeback-side handshakes (slave modport)
//   fflags_clr_i : clear sticky fflags
//   fflags_o     : sticky accumulated {NV,DZ,OF,UF,NX}
//   done_cnt_o   : number of dequeued results, modulo 2^CNT_WIDTH
//   occupancy_o  : number of entries currently held
module fpnew_noncomp_collector #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  fpnew_noncomp_collector_if.slave    bus,
  input  logic                        fflags_clr_i,
  output logic [4:0]                  fflags_o,
  output logic [CNT_WIDTH-1:0]        done_cnt_o,
  output logic [$clog2(DEPTH):0]      occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0]     result_q   [DEPTH];
  logic [4:0]           status_q   [DEPTH];
  logic                 ext_q      [DEPTH];
  logic [9:0]           mask_q     [DEPTH];
  logic                 is_class_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_q      [DEPTH];

  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]     occ_q;
  logic [4:0]           fflags_q;
  logic [CNT_WIDTH-1:0] done_cnt_q;

  logic in_ready, wb_valid, push, pop;

  // Ready and valid come from registered occupancy only, so a full FIFO
  // refuses a push even when it is popped in the same cycle, and an empty
  // FIFO never shows a result in its push cycle.
  assign in_ready = (occ_q < OCC_W'(DEPTH));
  assign wb_valid = (occ_q != '0);
  assign push     = bus.in_valid_i & in_ready & ~flush_i;
  assign pop      = wb_valid & bus.wb_ready_i;

  assign bus.in_ready_o  = in_ready;
  assign bus.wb_valid_o  = wb_valid;
  assign bus.wb_data_o   = is_class_q[rd_ptr_q]
                           ? {{(WIDTH-10){1'b0}}, mask_q[rd_ptr_q]}
                           : result_q[rd_ptr_q];
  assign bus.wb_ext_o    = ext_q[rd_ptr_q];
  assign bus.wb_status_o = status_q[rd_ptr_q];
  assign bus.wb_tag_o    = tag_q[rd_ptr_q];

  assign fflags_o    = fflags_q;
  assign done_cnt_o  = done_cnt_q;
  assign occupancy_o = occ_q;

  // Storage is cleared on reset so the head outputs read 0 rather than X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i]   <= '0;
        status_q[i]   <= '0;
        ext_q[i]      <= 1'b0;
        mask_q[i]     <= '0;
        is_class_q[i] <= 1'b0;
        tag_q[i]      <= '0;
      end
    end else if (push) begin
      result_q[wr_ptr_q]   <= bus.result_i;
      status_q[wr_ptr_q]   <= bus.status_i;
      ext_q[wr_ptr_q]      <= bus.extension_bit_i;
      mask_q[wr_ptr_q]     <= bus.class_mask_i;
      is_class_q[wr_ptr_q] <= bus.is_class_i;
      tag_q[wr_ptr_q]      <= bus.tag_i;
    end
  end

  // Flush returns both pointers and occupancy to zero, overriding any push
  // or pop in the same cycle; pointers otherwise wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // A pop during flush has already been handed off, so it still updates the
  // sticky flags and the counter. A clear together with a pop keeps only the
  // popped status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fflags_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q)
                  | (pop ? status_q[rd_ptr_q] : 5'b0);
      if (pop) done_cnt_q <= done_cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fpnew_noncomp_collector.sv
// tb_fpnew_noncomp_collector
//   Directed bench for fpnew_noncomp_collector. The DUT is built with
//   CNT_WIDTH=4 so that the counter wrap can be reached in a few cycles;
//   expDone follows the count modulo 16 across all scenarios.
module tb_fpnew_noncomp_collector;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned TAG_WIDTH = 1;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_WIDTH = 4;

  logic                 clk_i;
  logic                 rst_i;
  logic                 flush_i;
  logic                 fflags_clr_i;
  logic [4:0]           fflags_o;
  logic [CNT_WIDTH-1:0] done_cnt_o;
  logic [2:0]           occupancy_o;

  int checks;
  int errors;
  logic [CNT_WIDTH-1:0] expDone;

  fpnew_noncomp_collector_if #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

  fpnew_noncomp_collector #(
    .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .bus(bus),
    .fflags_clr_i(fflags_clr_i),
    .fflags_o(fflags_o),
    .done_cnt_o(done_cnt_o),
    .occupancy_o(occupancy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One clock edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i             = 1'b0;
    fflags_clr_i        = 1'b0;
    bus.in_valid_i      = 1'b0;
    bus.result_i        = '0;
    bus.status_i        = '0;
    bus.extension_bit_i = 1'b0;
    bus.class_mask_i    = '0;
    bus.is_class_i      = 1'b0;
    bus.tag_i           = '0;
    bus.wb_ready_i      = 1'b0;
  endtask

  task automatic offer(input logic [31:0] res, input logic [4:0] st, input logic tg);
    bus.in_valid_i = 1'b1;
    bus.result_i   = res;
    bus.status_i   = st;
    bus.tag_i      = tg;
    bus.is_class_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    #12;
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready_o); end
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", bus.wb_valid_o); end
    checks++; if (bus.wb_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_wb_data: got %h expected 0", bus.wb_data_o); end
    checks++; if ({bus.wb_ext_o, bus.wb_status_o, bus.wb_tag_o} !== 7'h0) begin errors++; $display("[TB] FAIL reset_head_fields: got %b expected 0", {bus.wb_ext_o, bus.wb_status_o, bus.wb_tag_o}); end
    checks++; if (fflags_o !== 5'h0) begin errors++; $display("[TB] FAIL reset_fflags: got %b expected 0", fflags_o); end
    checks++; if (done_cnt_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_done_cnt: got %0d expected 0", done_cnt_o); end
    checks++; if (occupancy_o !== 3'h0) begin errors++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy_o); end
    rst_i = 1'b0;
    expDone = '0;
    tick();
  endtask

  task automatic test_single();
    offer(32'h3F80_0000, 5'b0, 1'b1);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    checks++; if (bus.wb_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", bus.wb_valid_o); end
    checks++; if (bus.wb_data_o !== 32'h3F80_0000) begin errors++; $display("[TB] FAIL single_data: got %h expected 3f800000", bus.wb_data_o); end
    checks++; if (bus.wb_tag_o !== 1'b1) begin errors++; $display("[TB] FAIL single_tag: got %b expected 1", bus.wb_tag_o); end
    tick();
    expDone++;
    bus.wb_ready_i = 1'b0;
    checks++; if (done_cnt_o !== expDone) begin errors++; $display("[TB] FAIL single_done: got %0d expected %0d", done_cnt_o, expDone); end
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("[TB] FAIL single_occ: got %0d expected 0", occupancy_o); end
    checks++; if (fflags_o !== 5'b0) begin errors++; $display("[TB] FAIL single_fflags: got %b expected 0", fflags_o); end
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_empty: got %b expected 0", bus.wb_valid_o); end
  endtask

  task automatic test_classify();
    offer(32'hDEAD_BEEF, 5'b0, 1'b0);
    bus.is_class_i      = 1'b1;
    bus.class_mask_i    = 10'h040;
    bus.extension_bit_i = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.wb_data_o !== 32'h0000_0040) begin errors++; $display("[TB] FAIL classify_data: got %h expected 00000040", bus.wb_data_o); end
    checks++; if (bus.wb_ext_o !== 1'b1) begin errors++; $display("[TB] FAIL classify_ext: got %b expected 1", bus.wb_ext_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    expDone++;
    bus.wb_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.wb_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      offer(32'(i), 5'b0, 1'b0);
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_before_push%0d: got %b expected 1", i, bus.in_ready_o); end
      tick();
    end
    offer(32'h5, 5'b0, 1'b0);
    checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready: got %b expected 0", bus.in_ready_o); end
    checks++; if (occupancy_o !== 3'd4) begin errors++; $display("[TB] FAIL bp_full_occ: got %0d expected 4", occupancy_o); end
    tick();
    checks++; if (occupancy_o !== 3'd4) begin errors++; $display("[TB] FAIL bp_held_occ: got %0d expected 4", occupancy_o); end
    bus.wb_ready_i = 1'b1;
    checks++; if (bus.wb_data_o !== 32'h1) begin errors++; $display("[TB] FAIL bp_head1: got %h expected 1", bus.wb_data_o); end
    tick();
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", bus.in_ready_o); end
    checks++; if (occupancy_o !== 3'd3) begin errors++; $display("[TB] FAIL bp_occ_after_pop: got %0d expected 3", occupancy_o); end
    checks++; if (bus.wb_data_o !== 32'h2) begin errors++; $display("[TB] FAIL bp_head2: got %h expected 2", bus.wb_data_o); end
    tick();
    bus.in_valid_i = 1'b0;
    checks++; if (occupancy_o !== 3'd3) begin errors++; $display("[TB] FAIL bp_occ_push5: got %0d expected 3", occupancy_o); end
    for (int i = 3; i <= 5; i++) begin
      checks++; if (bus.wb_data_o !== 32'(i)) begin errors++; $display("[TB] FAIL bp_head%0d: got %h expected %h", i, bus.wb_data_o, 32'(i)); end
      tick();
    end
    bus.wb_ready_i = 1'b0;
    expDone += 4'd5;
    checks++; if (bus.wb_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin errors++; $display("[TB] FAIL bp_drained: got valid %b occ %0d expected 0 0", bus.wb_valid_o, occupancy_o); end
    checks++; if (done_cnt_o !== expDone) begin errors++; $display("[TB] FAIL bp_done: got %0d expected %0d", done_cnt_o, expDone); end
  endtask

  task automatic test_sticky_flags();
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    checks++; if (fflags_o !== 5'b0) begin errors++; $display("[TB] FAIL flags_cleared: got %b expected 00000", fflags_o); end
    offer(32'h10, 5'b10000, 1'b0); tick();
    offer(32'h11, 5'b00001, 1'b0); tick();
    offer(32'h12, 5'b00100, 1'b0); tick();
    bus.in_valid_i = 1'b0;
    checks++; if (bus.wb_status_o !== 5'b10000) begin errors++; $display("[TB] FAIL flags_head_status: got %b expected 10000", bus.wb_status_o); end
    checks++; if (fflags_o !== 5'b0) begin errors++; $display("[TB] FAIL flags_before_pop: got %b expected 00000", fflags_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    checks++; if (fflags_o !== 5'b10000) begin errors++; $display("[TB] FAIL flags_pop1: got %b expected 10000", fflags_o); end
    tick();
    checks++; if (fflags_o !== 5'b10001) begin errors++; $display("[TB] FAIL flags_pop2: got %b expected 10001", fflags_o); end
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i   = 1'b0;
    bus.wb_ready_i = 1'b0;
    expDone += 4'd3;
    checks++; if (fflags_o !== 5'b00100) begin errors++; $display("[TB] FAIL flags_clr_with_pop: got %b expected 00100", fflags_o); end
    checks++; if (done_cnt_o !== expDone) begin errors++; $display("[TB] FAIL flags_done: got %0d expected %0d", done_cnt_o, expDone); end
  endtask

  task automatic test_flush();
    offer(32'hA, 5'b01000, 1'b0); tick();
    offer(32'hB, 5'b00000, 1'b0); tick();
    offer(32'hC, 5'b00000, 1'b0); tick();
    checks++; if (occupancy_o !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_occ: got %0d expected 3", occupancy_o); end
    offer(32'hD, 5'b00010, 1'b0);
    flush_i        = 1'b1;
    bus.wb_ready_i = 1'b1;
    tick();
    idle_inputs();
    expDone++;
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("[TB] FAIL flush_occ: got %0d expected 0", occupancy_o); end
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", bus.wb_valid_o); end
    checks++; if (done_cnt_o !== expDone) begin errors++; $display("[TB] FAIL flush_done: got %0d expected %0d", done_cnt_o, expDone); end
    checks++; if (fflags_o !== 5'b01100) begin errors++; $display("[TB] FAIL flush_fflags: got %b expected 01100", fflags_o); end
    tick();
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("[TB] FAIL flush_dropped: got %0d expected 0", occupancy_o); end
    // After a flush the pointers restart, so a new result appears at the head.
    offer(32'hE, 5'b0, 1'b0);
    tick();
    bus.in_valid_i = 1'b0;
    checks++; if (bus.wb_data_o !== 32'hE) begin errors++; $display("[TB] FAIL flush_new_head: got %h expected e", bus.wb_data_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    expDone++;
  endtask

  task automatic test_async_reset();
    offer(32'h20, 5'b00001, 1'b0); tick();
    offer(32'h21, 5'b00001, 1'b0); tick();
    checks++; if (occupancy_o !== 3'd2) begin errors++; $display("[TB] FAIL areset_pre_occ: got %0d expected 2", occupancy_o); end
    offer(32'h22, 5'b0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", bus.wb_valid_o); end
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("[TB] FAIL areset_occ: got %0d expected 0", occupancy_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready: got %b expected 1", bus.in_ready_o); end
    checks++; if (done_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL areset_done: got %0d expected 0", done_cnt_o); end
    bus.in_valid_i = 1'b0;
    #1;
    rst_i   = 1'b0;
    expDone = '0;
    tick();
  endtask

  task automatic test_back_to_back_wrap();
    bus.wb_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      offer(32'h100 + 32'(i), 5'b0, 1'b0);
      tick();
      checks++; if (occupancy_o !== 3'd1) begin errors++; $display("[TB] FAIL b2b_occ_%0d: got %0d expected 1", i, occupancy_o); end
    end
    bus.in_valid_i = 1'b0;
    checks++; if (bus.wb_data_o !== 32'h110) begin errors++; $display("[TB] FAIL b2b_last_head: got %h expected 110", bus.wb_data_o); end
    tick();
    bus.wb_ready_i = 1'b0;
    checks++; if (done_cnt_o !== 4'd1) begin errors++; $display("[TB] FAIL wrap_done: got %0d expected 1", done_cnt_o); end
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("[TB] FAIL wrap_occ: got %0d expected 0", occupancy_o); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    expDone = '0;
    test_reset();
    test_single();
    test_classify();
    test_backpressure();
    test_sticky_flags();
    test_flush();
    test_async_reset();
    test_back_to_back_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
